// File: rtl/uart_cmd_engine.sv
// Command dispatcher between the UART frame core and the crypto coprocessor pair.
// Validates frames, decodes opcodes, drives the coprocessor and builds one reply per frame.
module uart_cmd_engine #(
    parameter int FRAME_BYTES = 18,
    parameter int DATA_W      = 128,
    parameter int NUM_SLOTS   = 2,
    parameter int CP_TIMEOUT  = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        frame_valid,
    input  logic [8*FRAME_BYTES-1:0]    frame_in,
    output logic [NUM_SLOTS*DATA_W-1:0] slot_data,
    output logic                        cp_start,
    output logic                        cp_sel,
    input  logic                        cp_done,
    input  logic [DATA_W-1:0]           cp_result,
    input  logic                        tx_busy,
    output logic                        tx_send,
    output logic [8*FRAME_BYTES-1:0]    tx_frame,
    output logic                        cmd_busy,
    output logic [7:0]                  err_count
);

    localparam int FW = 8 * FRAME_BYTES;
    localparam int TW = $clog2(CP_TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        CP_WAIT,
        TX_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [FW-1:0]       frame_q, frame_d;
    logic [DATA_W-1:0]   slot_q [NUM_SLOTS];
    logic [DATA_W-1:0]   slot_d [NUM_SLOTS];
    logic [DATA_W-1:0]   res_q, res_d;
    logic                res_vld_q, res_vld_d;
    logic                last_to_q, last_to_d;
    logic [7:0]          err_q, err_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic [FW-1:0]       tx_q, tx_d;
    logic                sel_q, sel_d;

    logic [7:0]          op;
    logic [7:0]          trl;
    logic [DATA_W-1:0]   pl;
    logic [3:0]          idx;
    logic                idx_ok;
    logic [DATA_W-1:0]   rd_slot;
    logic [1:0]          inc;
    logic [8:0]          err_sum;

    // Reply layout: tag in byte 0 and in the trailer, value in the payload.
    function automatic logic [FW-1:0] mk(input logic [7:0] tag,
                                         input logic [DATA_W-1:0] val);
        logic [FW-1:0] f;
        f = '0;
        f[7:0] = tag;
        f[FW-8 +: 8] = tag;
        f[8 +: DATA_W] = val;
        return f;
    endfunction

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        slot_d    = slot_q;
        res_d     = res_q;
        res_vld_d = res_vld_q;
        last_to_d = last_to_q;
        timer_d   = timer_q;
        tx_d      = tx_q;
        sel_d     = sel_q;
        cp_start  = 1'b0;
        tx_send   = 1'b0;
        inc       = 2'd0;

        op      = frame_q[7:0];
        trl     = frame_q[FW-8 +: 8];
        pl      = frame_q[8 +: DATA_W];
        idx     = op[3:0];
        idx_ok  = int'(idx) < NUM_SLOTS;
        rd_slot = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (idx == i[3:0]) rd_slot = slot_q[i];
        end

        // A frame arriving while a command is in flight is dropped.
        if (frame_valid && state_q != IDLE) inc = inc + 2'd1;

        unique case (state_q)
            IDLE: begin
                if (frame_valid) begin
                    frame_d = frame_in;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                state_d = TX_WAIT;
                timer_d = '0;
                if (op != trl) begin
                    tx_d = mk(8'h21, DATA_W'(op));
                    inc  = inc + 2'd1;
                end else if (op[7:4] == 4'h3 && idx_ok) begin
                    for (int i = 0; i < NUM_SLOTS; i++) begin
                        if (idx == i[3:0]) slot_d[i] = pl;
                    end
                    tx_d = mk(op, '0);
                end else if (op[7:4] == 4'h6 && idx_ok) begin
                    tx_d = mk(op, rd_slot);
                end else if (op == 8'h45 || op == 8'h44) begin
                    cp_start = 1'b1;
                    sel_d    = (op == 8'h44);
                    state_d  = CP_WAIT;
                end else if (op == 8'h52) begin
                    tx_d = mk(op, res_q);
                end else if (op == 8'h53) begin
                    tx_d = mk(op, DATA_W'({6'b0, last_to_q, res_vld_q}));
                end else begin
                    tx_d = mk(8'h21, DATA_W'(op));
                end
            end
            CP_WAIT: begin
                if (cp_done) begin
                    res_d     = cp_result;
                    res_vld_d = 1'b1;
                    last_to_d = 1'b0;
                    tx_d      = mk(op, cp_result);
                    state_d   = TX_WAIT;
                end else if (timer_q == TW'(CP_TIMEOUT - 1)) begin
                    last_to_d = 1'b1;
                    inc       = inc + 2'd1;
                    tx_d      = mk(8'h21, DATA_W'(op));
                    state_d   = TX_WAIT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            TX_WAIT: begin
                if (!tx_busy) begin
                    tx_send = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        err_sum = {1'b0, err_q} + {7'b0, inc};
        err_d   = err_sum[8] ? 8'hFF : err_sum[7:0];

        if (reset) begin
            cp_start = 1'b0;
            tx_send  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            frame_q   <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) slot_q[i] <= '0;
            res_q     <= '0;
            res_vld_q <= 1'b0;
            last_to_q <= 1'b0;
            err_q     <= '0;
            timer_q   <= '0;
            tx_q      <= '0;
            sel_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            slot_q    <= slot_d;
            res_q     <= res_d;
            res_vld_q <= res_vld_d;
            last_to_q <= last_to_d;
            err_q     <= err_d;
            timer_q   <= timer_d;
            tx_q      <= tx_d;
            sel_q     <= sel_d;
        end
    end

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        assign slot_data[DATA_W*g +: DATA_W] = slot_q[g];
    end

    // Select must be valid in the launch cycle, before sel_q is loaded.
    assign cp_sel    = (state_q == DECODE && cp_start) ? (op == 8'h44) : sel_q;
    assign tx_frame  = tx_q;
    assign cmd_busy  = (state_q != IDLE);
    assign err_count = err_q;

endmodule

// File: tb/tb_uart_cmd_engine.sv
// Scoreboard bench for uart_cmd_engine: expected reply frames are queued by the
// stimulus and popped by a monitor on every tx_send.
module tb_uart_cmd_engine;

    localparam int FB = 18;
    localparam int FW = 8 * FB;
    localparam int DW = 128;
    localparam int NS = 2;
    localparam int TO = 1024;

    localparam logic [127:0] K1 = 128'hf34481ec3cc627bacd5dc3fb08f273e6;
    localparam logic [127:0] R1 = 128'h0336763e966d92595a567cc9ce537f5e;
    localparam logic [127:0] R2 = 128'h0123456789abcdef0011223344556677;

    logic               clk;
    logic               reset;
    logic               frame_valid;
    logic [FW-1:0]      frame_in;
    logic [NS*DW-1:0]   slot_data;
    logic               cp_start;
    logic               cp_sel;
    logic               cp_done;
    logic [DW-1:0]      cp_result;
    logic               tx_busy;
    logic               tx_send;
    logic [FW-1:0]      tx_frame;
    logic               cmd_busy;
    logic [7:0]         err_count;

    uart_cmd_engine #(
        .FRAME_BYTES(FB),
        .DATA_W(DW),
        .NUM_SLOTS(NS),
        .CP_TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .frame_valid(frame_valid),
        .frame_in(frame_in),
        .slot_data(slot_data),
        .cp_start(cp_start),
        .cp_sel(cp_sel),
        .cp_done(cp_done),
        .cp_result(cp_result),
        .tx_busy(tx_busy),
        .tx_send(tx_send),
        .tx_frame(tx_frame),
        .cmd_busy(cmd_busy),
        .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Coprocessor model: answers cp_start after cp_delay cycles when enabled.
    bit           cp_en = 1'b0;
    int           cp_delay = 20;
    logic [DW-1:0] cp_val = '0;
    int           cd = 0;
    int           done_cyc = 0;
    initial begin
        cp_done = 1'b0;
        cp_result = '0;
    end
    always @(posedge clk) begin
        cp_done <= 1'b0;
        if (cd > 0) begin
            cd <= cd - 1;
            if (cd == 1) begin
                cp_done   <= 1'b1;
                cp_result <= cp_val;
                done_cyc  <= cyc + 1;
            end
        end else if (cp_start && cp_en) begin
            cd <= cp_delay;
        end
    end

    int   n_start = 0;
    int   start_cyc = 0;
    logic start_sel = 1'b0;
    always @(negedge clk) begin
        if (cp_start === 1'b1) begin
            n_start   <= n_start + 1;
            start_cyc <= cyc;
            start_sel <= cp_sel;
        end
    end

    logic [FW-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail = 0;
    int n_tx = 0;
    int last_tx_cyc = 0;
    int fv_cyc = 0;

    function automatic logic [FW-1:0] mk(input logic [7:0] b0,
                                         input logic [7:0] tl,
                                         input logic [127:0] p);
        logic [FW-1:0] f;
        f = '0;
        f[7:0] = b0;
        f[FW-8 +: 8] = tl;
        f[8 +: 128] = p;
        return f;
    endfunction

    function automatic logic [FW-1:0] nak(input logic [7:0] op);
        return mk(8'h21, 8'h21, {120'b0, op});
    endfunction

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic monitor();
        logic [FW-1:0] e;
        forever begin
            @(negedge clk);
            if (tx_send === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_tx: got %h expected no reply", tx_frame);
                end else begin
                    e = exp_q.pop_front();
                    chk("tx_frame", 256'(tx_frame), 256'(e));
                end
                n_tx++;
                last_tx_cyc = cyc;
            end
        end
    endtask

    task automatic send(input logic [7:0] op, input logic [7:0] tl,
                        input logic [127:0] p);
        @(posedge clk);
        #1;
        frame_in    = mk(op, tl, p);
        frame_valid = 1'b1;
        fv_cyc      = cyc;
        @(posedge clk);
        #1;
        frame_valid = 1'b0;
    endtask

    task automatic wait_tx(input string nm, input int bound);
        int s;
        int k;
        s = n_tx;
        k = 0;
        while (n_tx == s && k < bound) begin
            @(posedge clk);
            k++;
        end
        if (n_tx == s) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: got no tx_send expected one within %0d cycles", nm, bound);
        end
        #1;
    endtask

    initial begin
        int n0;
        int lat;
        logic [FW-1:0] snap;

        reset       = 1'b1;
        frame_valid = 1'b0;
        frame_in    = '0;
        tx_busy     = 1'b0;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        chk_i("rst_err", int'(err_count), 0);
        chk("rst_slots", 256'(slot_data), 256'(0));
        chk("rst_tx_frame", 256'(tx_frame), 256'(0));
        chk_i("rst_busy", int'(cmd_busy), 0);
        chk_i("rst_sel", int'(cp_sel), 0);

        exp_q.push_back(mk(8'h30, 8'h30, 128'h0));
        send(8'h30, 8'h30, 128'h0);
        wait_tx("ack0", 10);
        chk_i("ack0_latency", last_tx_cyc - fv_cyc, 2);
        chk("slot0", 256'(slot_data[127:0]), 256'(0));

        exp_q.push_back(mk(8'h31, 8'h31, 128'h0));
        send(8'h31, 8'h31, K1);
        wait_tx("ack1", 10);
        chk("slot1", 256'(slot_data[255:128]), 256'(K1));

        n0 = n_start;
        exp_q.push_back(nak(8'h45));
        send(8'h45, 8'h58, K1);
        wait_tx("nak_frame", 10);
        chk_i("frame_err_count", int'(err_count), 1);
        chk_i("frame_err_no_start", n_start - n0, 0);

        cp_en = 1'b0;
        n0 = n_start;
        exp_q.push_back(nak(8'h44));
        send(8'h44, 8'h44, 128'h0);
        wait_tx("timeout", TO + 20);
        chk_i("d_start", n_start - n0, 1);
        chk_i("d_sel", int'(start_sel), 1);
        lat = last_tx_cyc - fv_cyc;
        n_tests++;
        if (lat < TO + 1 || lat > TO + 3) begin
            n_fail++;
            $display("FAIL timeout_latency: got %0d expected %0d..%0d", lat, TO + 1, TO + 3);
        end
        chk_i("timeout_err_count", int'(err_count), 2);

        exp_q.push_back(mk(8'h53, 8'h53, 128'h02));
        send(8'h53, 8'h53, 128'h0);
        wait_tx("status_to", 10);

        cp_en    = 1'b1;
        cp_delay = 20;
        cp_val   = R1;
        n0 = n_start;
        exp_q.push_back(mk(8'h45, 8'h45, R1));
        send(8'h45, 8'h45, 128'h0);
        wait_tx("enc", 60);
        chk_i("e_start", n_start - n0, 1);
        chk_i("e_sel", int'(start_sel), 0);
        chk_i("e_start_cycle", start_cyc - fv_cyc, 1);
        chk_i("e_done_to_tx", last_tx_cyc - done_cyc, 1);

        exp_q.push_back(mk(8'h52, 8'h52, R1));
        send(8'h52, 8'h52, 128'h0);
        wait_tx("read_res", 10);
        cp_en = 1'b0;

        tx_busy = 1'b1;
        n0 = n_tx;
        exp_q.push_back(mk(8'h61, 8'h61, K1));
        send(8'h61, 8'h61, 128'h0);
        repeat (5) @(posedge clk);
        #1 snap = tx_frame;
        chk("busy_frame", 256'(snap), 256'(mk(8'h61, 8'h61, K1)));
        send(8'h30, 8'h30, K1);
        repeat (40) @(posedge clk);
        #1;
        chk("busy_stable", 256'(tx_frame), 256'(snap));
        chk_i("busy_no_send", n_tx - n0, 0);
        chk_i("overrun_err", int'(err_count), 3);
        tx_busy = 1'b0;
        wait_tx("busy_release", 10);
        repeat (5) @(posedge clk);
        #1;
        chk_i("busy_single_send", n_tx - n0, 1);
        chk("overrun_dropped", 256'(slot_data[127:0]), 256'(0));

        for (int i = 0; i < 300; i++) begin
            exp_q.push_back(nak(8'h41));
            send(8'h41, 8'h42, 128'h0);
            wait_tx("sat_nak", 10);
        end
        chk_i("err_saturate", int'(err_count), 255);

        cp_en    = 1'b1;
        cp_delay = 30;
        cp_val   = R2;
        n0 = n_start;
        send(8'h45, 8'h45, 128'h0);
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        lat = n_tx;
        repeat (50) @(posedge clk);
        #1;
        chk_i("rst_mid_no_tx", n_tx - lat, 0);
        chk_i("rst_mid_start_once", n_start - n0, 1);
        chk_i("rst_mid_err", int'(err_count), 0);
        chk("rst_mid_slots", 256'(slot_data), 256'(0));
        chk("rst_mid_tx_frame", 256'(tx_frame), 256'(0));
        chk_i("rst_mid_busy", int'(cmd_busy), 0);
        chk_i("rst_mid_sel", int'(cp_sel), 0);
        cp_en = 1'b0;

        exp_q.push_back(mk(8'h52, 8'h52, 128'h0));
        send(8'h52, 8'h52, 128'h0);
        wait_tx("rst_read_res", 10);
        exp_q.push_back(mk(8'h53, 8'h53, 128'h0));
        send(8'h53, 8'h53, 128'h0);
        wait_tx("rst_status", 10);
        chk_i("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
